// File: rtl/robertson_mult_seq_if.sv
// Handshake/operand bundle for the Robertson sequential multiplier.
// The master issues start with operands; the slave returns busy/done and a held product.
interface robertson_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/robertson_mult_seq.sv
// Sequential two's-complement multiplier (Robertson): one multiplier bit per clock.
// Handshake: start is accepted only in IDLE or DONE; busy spans the WIDTH step cycles; done pulses once.
module robertson_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  robertson_mult_seq_if.slave   bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH:0]     a;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic [CNTW-1:0]    count;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  logic               last;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     operand;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     s;
  logic [WIDTH:0]     a_next;
  logic [WIDTH-1:0]   q_next;

  // The final step weighs the multiplier sign bit negatively, so it subtracts M
  // (implemented as add of ~M with carry-in).
  always_comb begin
    last    = (count == CNTW'(WIDTH - 1));
    m_ext   = {m[WIDTH-1], m};
    operand = last ? ~m_ext : m_ext;
    sum     = a + operand + {{WIDTH{1'b0}}, last};
    s       = q[0] ? sum : a;
    a_next  = {s[WIDTH], s[WIDTH:1]};
    q_next  = {s[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m     <= bus.multiplicand;
            q     <= bus.multiplier;
            a     <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a <= a_next;
          q <= q_next;
          if (last) begin
            product <= {a_next[WIDTH-1:0], q_next};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            count <= count + CNTW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.product = product;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign dbg_state   = state;

endmodule
